alu_ctrl_md: RTL and testbench

- Second-generation ALU control for the RV32 core.
- Decodes ALUOp/Funct3/Funct7 into the EX-stage ALU select, with strict Funct7 checking.
- Adds RV32M support: MUL* ops complete in one cycle; DIV/REM ops run on an iterative radix-2 divider inside this block.
- While an M op is in flight, the block stalls the pipeline through a Valid/Stall/Done handshake.

---
 rtl/alu_ctrl_md.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// ALU control with RV32M: combinational ALU-select decode, one-cycle multiply and a
// radix-2 iterative divider with a Valid/Stall/Done handshake. Optional macro: ALU_CTRL_MD_DIV_EARLY_OUT_EN.
module alu_ctrl_md #(
  parameter int XLEN  = 32,
  parameter int SIG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ALUOp,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             Valid,
  input  logic             Flush,
  input  logic [XLEN-1:0]  Rs1Data,
  input  logic [XLEN-1:0]  Rs2Data,
  output logic [SIG_W-1:0] ALUSignal,
  output logic             IsMd,
  output logic             Stall,
  output logic             MdDone,
  output logic [XLEN-1:0]  MdResult,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(XLEN);

  localparam logic [SIG_W-1:0] SIG_ADD  = SIG_W'(0);
  localparam logic [SIG_W-1:0] SIG_SUB  = SIG_W'(1);
  localparam logic [SIG_W-1:0] SIG_SLL  = SIG_W'(2);
  localparam logic [SIG_W-1:0] SIG_SLT  = SIG_W'(3);
  localparam logic [SIG_W-1:0] SIG_SLTU = SIG_W'(4);
  localparam logic [SIG_W-1:0] SIG_XOR  = SIG_W'(5);
  localparam logic [SIG_W-1:0] SIG_SRL  = SIG_W'(6);
  localparam logic [SIG_W-1:0] SIG_SRA  = SIG_W'(7);
  localparam logic [SIG_W-1:0] SIG_OR   = SIG_W'(8);
  localparam logic [SIG_W-1:0] SIG_AND  = SIG_W'(9);
  localparam logic [SIG_W-1:0] SIG_MUL  = SIG_W'(10);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  // Multiplies finish on the start edge itself, so there is no separate multiply state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  function automatic logic [SIG_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b001:  return SIG_SLL;
      3'b010:  return SIG_SLT;
      3'b011:  return SIG_SLTU;
      3'b100:  return SIG_XOR;
      3'b101:  return SIG_SRL;
      3'b110:  return SIG_OR;
      3'b111:  return SIG_AND;
      default: return SIG_ADD;
    endcase
  endfunction

  // Divide-by-zero and signed-overflow results; div0 takes precedence.
  function automatic logic [XLEN-1:0] special_res(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] a,
                                                  input logic div0);
    if (div0) return f3[1] ? a : '1;
    else      return f3[1] ? '0 : a;
  endfunction

  always_comb begin
    ALUSignal = SIG_ADD;
    IsMd      = 1'b0;
    case (ALUOp)
      3'b000: begin
        if (Funct7 == F7_BASE) begin
          ALUSignal = base_op(Funct3);
        end else if (Funct7 == F7_ALT) begin
          if (Funct3 == 3'b000)      ALUSignal = SIG_SUB;
          else if (Funct3 == 3'b101) ALUSignal = SIG_SRA;
        end else if (Funct7 == F7_MD) begin
          ALUSignal = SIG_MUL + SIG_W'(Funct3);
          IsMd      = 1'b1;
        end
      end
      3'b001: begin
        if (Funct3 == 3'b101) ALUSignal = (Funct7 == F7_ALT) ? SIG_SRA : SIG_SRL;
        else                  ALUSignal = base_op(Funct3);
      end
      3'b011:  ALUSignal = SIG_SUB;
      default: ALUSignal = SIG_ADD;
    endcase
  end

  logic start;
  logic a_neg_in, b_neg_in, div0_in, ovf_in;
  logic [XLEN-1:0] a_abs_in, b_abs_in;

  assign start    = Valid & IsMd & (state == S_IDLE) & ~Flush;
  assign a_neg_in = ~Funct3[0] & Rs1Data[XLEN-1];
  assign b_neg_in = ~Funct3[0] & Rs2Data[XLEN-1];
  assign a_abs_in = a_neg_in ? (~Rs1Data + 1'b1) : Rs1Data;
  assign b_abs_in = b_neg_in ? (~Rs2Data + 1'b1) : Rs2Data;
  assign div0_in  = (Rs2Data == '0);
  assign ovf_in   = ~Funct3[0] & (Rs1Data == {1'b1, {(XLEN-1){1'b0}}}) & (Rs2Data == '1);

  // Both operands extended to 2*XLEN so one unsigned multiplier covers all four signedness mixes.
  logic              ma_sgn, mb_sgn;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]   mul_res;

  assign ma_sgn  = (Funct3[1:0] != 2'b11) & Rs1Data[XLEN-1];
  assign mb_sgn  = (Funct3[1:0] == 2'b01) & Rs2Data[XLEN-1];
  assign ma      = {{XLEN{ma_sgn}}, Rs1Data};
  assign mb      = {{XLEN{mb_sgn}}, Rs2Data};
  assign prod    = ma * mb;
  assign mul_res = (Funct3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_raw_q, quo_q, rem_q, dvs_q, md_result_q;
  logic            a_neg_q, b_neg_q, div0_q, ovf_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   shifted, diff;
  logic            q_bit;
  logic [XLEN-1:0] quo_n, rem_n, quo_fix, rem_fix, div_final;

  // Restoring step: dividend bits shift out of quo_q into the partial remainder.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign q_bit     = ~diff[XLEN];
  assign rem_n     = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_n     = {quo_q[XLEN-2:0], q_bit};
  assign quo_fix   = (a_neg_q ^ b_neg_q) ? (~quo_n + 1'b1) : quo_n;
  assign rem_fix   = a_neg_q ? (~rem_n + 1'b1) : rem_n;
  assign div_final = (div0_q | ovf_q) ? special_res(op_q, a_raw_q, div0_q)
                                      : (op_q[1] ? rem_fix : quo_fix);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!Funct3[2]) begin
            state_n = S_DONE;
          end else begin
`ifdef ALU_CTRL_MD_DIV_EARLY_OUT_EN
            state_n = (div0_in || ovf_in) ? S_DONE : S_DIV;
`else
            state_n = S_DIV;
`endif
          end
        end
      end
      S_DIV: begin
        if (Flush)               state_n = S_IDLE;
        else if (cnt_q == '0)    state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_raw_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      md_result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= Funct3;
            a_raw_q <= Rs1Data;
            quo_q   <= a_abs_in;
            rem_q   <= '0;
            dvs_q   <= b_abs_in;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
            cnt_q   <= CW'(XLEN - 1);
            if (!Funct3[2]) begin
              md_result_q <= mul_res;
            end
`ifdef ALU_CTRL_MD_DIV_EARLY_OUT_EN
            else if (div0_in || ovf_in) begin
              md_result_q <= special_res(Funct3, Rs1Data, div0_in);
            end
`endif
          end
        end
        S_DIV: begin
          if (!Flush) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) md_result_q <= div_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign MdDone    = (state == S_DONE);
  assign MdResult  = md_result_q;
  assign Stall     = Valid & IsMd & ~MdDone & ~Flush;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode table, M-op scoreboard with latency checks,
// flush and asynchronous reset mid-divide. Honours ALU_CTRL_MD_DIV_EARLY_OUT_EN for latency.
module tb_alu_ctrl_md;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ALUOp, Funct3;
  logic [6:0]  Funct7;
  logic        Valid, Flush;
  logic [31:0] Rs1Data, Rs2Data;
  logic [4:0]  ALUSignal;
  logic        IsMd, Stall, MdDone;
  logic [31:0] MdResult;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  alu_ctrl_md #(.XLEN(32), .SIG_W(5)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7),
    .Valid(Valid), .Flush(Flush), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
    .ALUSignal(ALUSignal), .IsMd(IsMd), .Stall(Stall), .MdDone(MdDone),
    .MdResult(MdResult), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (MdDone === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

`ifdef ALU_CTRL_MD_DIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // reference model
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint ps;
    logic [63:0] pu;
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin ps = longint'(ia) * longint'(ib); pu = ps; return pu[63:32]; end
      3'd2: begin ps = longint'(ia) * longint'({32'b0, b}); pu = ps; return pu[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SPECIAL_LAT;
    return 33;
  endfunction

  // driver tasks
  task automatic dec(input string tag, input logic [2:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] exp_sig, input logic exp_md);
    @(negedge clk);
    ALUOp = op; Funct3 = f3; Funct7 = f7;
    #1;
    check({tag, " sig"}, {27'b0, ALUSignal}, {27'b0, exp_sig});
    check({tag, " ismd"}, {31'b0, IsMd}, {31'b0, exp_md});
  endtask

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUOp = 3'b000; Funct7 = 7'b0000001; Funct3 = f3;
    Rs1Data = a; Rs2Data = b; Valid = 1'b1;
  endtask

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat_exp;
    int lat;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    drive_md(f3, a, b);
    exp_q.push_back(ref_md(f3, a, b));
    lat_exp = exp_lat(f3, a, b);
    #1 check({tag, " stall0"}, {31'b0, Stall}, 32'd1);
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk); #1;
      lat++;
      if (MdDone === 1'b1) begin
        got = 1;
        e = exp_q.pop_front();
        last_exp = e;
        check({tag, " latency"}, lat, lat_exp);
        check({tag, " result"}, MdResult, e);
        check({tag, " stall_done"}, {31'b0, Stall}, 32'd0);
      end else if (lat == lat_exp) begin
        check({tag, " done_missing"}, {31'b0, MdDone}, 32'd1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL %s timeout observed=no_done expected=done", tag);
      void'(exp_q.pop_front());
    end
    Valid = 1'b0;
  endtask

  initial begin
    int base;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    rst = 1'b1; Valid = 1'b0; Flush = 1'b0;
    ALUOp = 3'b000; Funct3 = 3'b000; Funct7 = 7'b0; Rs1Data = '0; Rs2Data = '0;
    last_exp = '0;
    #1;
    check("reset mddone", {31'b0, MdDone}, 32'd0);
    check("reset mdresult", MdResult, 32'd0);
    check("reset stall", {31'b0, Stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    dec("r_sub",    3'b000, 3'b000, 7'b0100000, 5'd1,  1'b0);
    dec("r_badf7",  3'b000, 3'b000, 7'b0000101, 5'd0,  1'b0);
    dec("r_and",    3'b000, 3'b111, 7'b0000000, 5'd9,  1'b0);
    dec("r_sltu",   3'b000, 3'b011, 7'b0000000, 5'd4,  1'b0);
    dec("i_sra",    3'b001, 3'b101, 7'b0100000, 5'd7,  1'b0);
    dec("i_srl",    3'b001, 3'b101, 7'b0000001, 5'd6,  1'b0);
    dec("i_add",    3'b001, 3'b000, 7'b0100000, 5'd0,  1'b0);
    dec("b_sub",    3'b011, 3'b110, 7'b0000000, 5'd1,  1'b0);
    dec("s_add",    3'b010, 3'b111, 7'b0000000, 5'd0,  1'b0);
    dec("u_nomd",   3'b100, 3'b110, 7'b0000001, 5'd0,  1'b0);
    dec("r_rem",    3'b000, 3'b110, 7'b0000001, 5'd16, 1'b1);
    dec("r_mulhu",  3'b000, 3'b011, 7'b0000001, 5'd13, 1'b1);

    run_md("mulh",     3'd1, 32'h8000_0000, 32'h0000_0002);
    run_md("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    run_md("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002);
    run_md("divu_z",   3'd5, 32'h0000_1234, 32'h0000_0000);
    run_md("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_z",    3'd4, 32'hFFFF_FFF9, 32'h0000_0000);
    run_md("remu_z",   3'd7, 32'hDEAD_BEEF, 32'h0000_0000);
    run_md("mul_lo",   3'd0, 32'hFFFF_FFFF, 32'h0000_0003);
    run_md("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      run_md("rand", rf3, ra, rb);
    end

    repeat (3) @(negedge clk);
    #1 check("hold result", MdResult, last_exp);

    // Flush mid-divide: no pulse, result untouched, next op runs normally.
    base = done_cnt;
    @(negedge clk);
    drive_md(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (10) @(negedge clk);
    Flush = 1'b1;
    #1 check("flush stall", {31'b0, Stall}, 32'd0);
    @(negedge clk);
    Flush = 1'b0; Valid = 1'b0;
    #1;
    check("flush idle", {30'b0, dbg_state}, 32'd0);
    check("flush result", MdResult, last_exp);
    repeat (40) @(negedge clk);
    #1 check("flush no_done", done_cnt, base);
    run_md("mul_after_flush", 3'd0, 32'h0001_0001, 32'h0000_0010);
    check("flush one_done", done_cnt, base + 1);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    drive_md(3'd5, 32'h0000_1000, 32'h0000_0007);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst mddone", {31'b0, MdDone}, 32'd0);
    check("arst mdresult", MdResult, 32'd0);
    check("arst state", {30'b0, dbg_state}, 32'd0);
    check("arst stall", {31'b0, Stall}, 32'd1);
    @(negedge clk);
    Valid = 1'b0; rst = 1'b0;
    run_md("mulhu_after_rst", 3'd3, 32'hFFFF_FFFF, 32'h0000_0010);

    check("queue empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
